// File: rtl/adc_avg_fifo_pkg.sv
// Shared definitions for the ADC averaging FIFO slice.
//   ADC_WIDTH : width of the SAR result bus
//   state_t   : sequencer states (IDLE=0, CONV=1, HOLD=2)
package adc_avg_fifo_pkg;

    localparam int ADC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/adc_avg_fifo_if.sv
// Valid/ready output stream carrying averaged ADC words.
//   m_data  : FIFO head word, meaningful while m_valid=1
//   m_valid : FIFO not empty
//   m_ready : consumer accepts m_data when m_valid && m_ready
interface adc_avg_fifo_if;
    import adc_avg_fifo_pkg::*;

    logic [ADC_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_data, output m_valid, input  m_ready);
    modport slave  (input  m_data, input  m_valid, output m_ready);

endinterface

// File: rtl/adc_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; dropped when full unless popping
//   pop        : read request; ignored when empty
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
//   dout       : head word, valid while !empty
module adc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [WIDTH-1:0]           dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adc_avg_fifo.sv
// SAR consumer: enables the converter, averages 2^AVG_LOG2 conversions with
// round-half-up and queues the averages in an FWFT FIFO. A full FIFO parks
// the sequencer in HOLD, which idles the SAR until space frees up.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : 1 = convert continuously, 0 = idle the SAR
//   adc_done    : one-cycle conversion-complete strobe
//   adc_value   : SAR result, valid while adc_done=1
//   adc_enable  : registered SAR enable, 1 only in CONV
//   m           : valid/ready output stream (master side)
//   fifo_level  : FIFO occupancy
//   overrun     : sticky push-while-full flag, cleared on a run 0->1 edge
module adc_avg_fifo
    import adc_avg_fifo_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          adc_done,
    input  logic [ADC_WIDTH-1:0]          adc_value,
    output logic                          adc_enable,
    adc_avg_fifo_if.master                m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun
);
    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int RND   = (1 << AVG_LOG2) >> 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);

    state_t               state;
    state_t               state_nxt;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     sum;
    logic [CNT_W-1:0]     cnt;
    logic [ADC_WIDTH-1:0] push_word;
    logic                 capture;
    logic                 last_cap;
    logic                 push_req;
    logic                 push_ok;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [LW-1:0]        lvl_nxt;
    logic                 will_full;
    logic                 leave_conv;
    logic                 run_q;

    assign capture  = (state == CONV) && adc_done;
    // With AVG_LOG2=0 cnt never leaves 0, so every capture is the last one.
    assign last_cap = (cnt == CNT_LAST);
    assign push_req = capture && last_cap;
    assign pop      = m.m_valid && m.m_ready;

    // Sum of the whole group plus half an LSB; 255*2^N + 2^(N-1) fits in ACC_W.
    assign sum       = acc + ACC_W'(adc_value) + ACC_W'(RND);
    assign push_word = ADC_WIDTH'(sum >> AVG_LOG2);

    // Occupancy after this cycle's push/pop, so CONV parks before overfilling.
    assign push_ok   = push_req && (!full || pop);
    assign lvl_nxt   = fifo_level + LW'(push_ok) - LW'(pop);
    assign will_full = (lvl_nxt == FULL_LVL);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (run) state_nxt = full ? HOLD : CONV;
            CONV: begin
                if (!run)           state_nxt = IDLE;
                else if (will_full) state_nxt = HOLD;
            end
            HOLD: begin
                if (!run)       state_nxt = IDLE;
                else if (!full) state_nxt = CONV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign leave_conv = (state == CONV) && (state_nxt != CONV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            adc_enable <= 1'b0;
        end else begin
            state      <= state_nxt;
            adc_enable <= (state_nxt == CONV);
        end
    end

    // Leaving CONV aborts the SAR, so any partial group is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (leave_conv || push_req) begin
            acc <= '0;
            cnt <= '0;
        end else if (capture) begin
            acc <= acc + ACC_W'(adc_value);
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            run_q <= run;
            if (run && !run_q)
                overrun <= 1'b0;
            else if (push_req && full && !pop)
                overrun <= 1'b1;
        end
    end

    assign m.m_valid = !empty;

    adc_sync_fifo #(
        .WIDTH (ADC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .din   (push_word),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .level (fifo_level),
        .dout  (m.m_data)
    );

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Directed bench: u_dut0 averages groups of 4 into a 4-deep FIFO,
// u_dut1 passes single conversions into a 2-deep FIFO.
module tb_adc_avg_fifo;
    import adc_avg_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       run0 = 1'b0, done0 = 1'b0;
    logic [7:0] val0 = '0;
    logic       en0, ovr0;
    logic [2:0] lvl0;

    logic       run1 = 1'b0, done1 = 1'b0;
    logic [7:0] val1 = '0;
    logic       en1, ovr1;
    logic [1:0] lvl1;

    adc_avg_fifo_if if0();
    adc_avg_fifo_if if1();

    adc_avg_fifo #(.AVG_LOG2(2), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0), .adc_done(done0), .adc_value(val0),
        .adc_enable(en0), .m(if0), .fifo_level(lvl0), .overrun(ovr0)
    );

    adc_avg_fifo #(.AVG_LOG2(0), .FIFO_DEPTH(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .run(run1), .adc_done(done1), .adc_value(val1),
        .adc_enable(en1), .m(if1), .fifo_level(lvl1), .overrun(ovr1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One conversion: done high for one cycle; returns at the negedge after the capturing edge.
    task automatic pulse0(input logic [7:0] v);
        @(negedge clk); val0 = v; done0 = 1'b1;
        @(negedge clk); done0 = 1'b0;
    endtask

    task automatic pulse1(input logic [7:0] v);
        @(negedge clk); val1 = v; done1 = 1'b1;
        @(negedge clk); done1 = 1'b0;
    endtask

    task automatic group0(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        pulse0(a); pulse0(b); pulse0(c); pulse0(d);
    endtask

    task automatic wait_en0(input int budget);
        int k = 0;
        while (!en0 && k < budget) begin @(negedge clk); k++; end
        check_eq("en0_up", en0, 1);
    endtask

    task automatic wait_en1(input int budget);
        int k = 0;
        while (!en1 && k < budget) begin @(negedge clk); k++; end
        check_eq("en1_up", en1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.m_ready = 1'b0;
        if1.m_ready = 1'b0;

        // Reset values
        #2;
        check_eq("rst_en0", en0, 0);
        check_eq("rst_valid0", if0.m_valid, 0);
        check_eq("rst_lvl0", lvl0, 0);
        check_eq("rst_ovr0", ovr0, 0);
        check_eq("rst_en1", en1, 0);
        check_eq("rst_valid1", if1.m_valid, 0);
        check_eq("rst_lvl1", lvl1, 0);
        check_eq("rst_ovr1", ovr1, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1: 10,11,12,13 -> (46+2)>>2 = 12
        if0.m_ready = 1'b1;
        run0 = 1'b1;
        wait_en0(5);
        group0(8'd10, 8'd11, 8'd12, 8'd13);
        check_eq("t1_valid", if0.m_valid, 1);
        check_eq("t1_data", if0.m_data, 12);
        check_eq("t1_lvl", lvl0, 1);
        @(negedge clk);
        check_eq("t1_lvl_drain", lvl0, 0);

        // 2: 4x255 -> 255; 0,0,0,2 -> (2+2)>>2 = 1
        group0(8'd255, 8'd255, 8'd255, 8'd255);
        check_eq("t2_max", if0.m_data, 255);
        @(negedge clk);
        group0(8'd0, 8'd0, 8'd0, 8'd2);
        check_eq("t2_round", if0.m_data, 1);
        @(negedge clk);

        // 3: fill with m_ready=0, then single pop and drain in order
        if0.m_ready = 1'b0;
        group0(8'd40, 8'd40, 8'd40, 8'd40);
        group0(8'd50, 8'd50, 8'd50, 8'd50);
        group0(8'd60, 8'd60, 8'd60, 8'd60);
        group0(8'd70, 8'd70, 8'd70, 8'd70);
        check_eq("t3_lvl_full", lvl0, 4);
        check_eq("t3_en_hold", en0, 0);
        pulse0(8'd99);
        check_eq("t3_hold_ignore", lvl0, 4);
        check_eq("t3_head_stable", if0.m_data, 40);
        if0.m_ready = 1'b1;
        @(negedge clk);
        if0.m_ready = 1'b0;
        check_eq("t3_lvl_pop", lvl0, 3);
        check_eq("t3_head2", if0.m_data, 50);
        wait_en0(2);
        if0.m_ready = 1'b1;
        check_eq("t3_d50", if0.m_data, 50);
        @(negedge clk);
        check_eq("t3_d60", if0.m_data, 60);
        @(negedge clk);
        check_eq("t3_d70", if0.m_data, 70);
        @(negedge clk);
        check_eq("t3_lvl_empty", lvl0, 0);
        check_eq("t3_ovr", ovr0, 0);

        // 4: partial group discarded across a run pause
        pulse0(8'd100);
        pulse0(8'd100);
        run0 = 1'b0;
        @(negedge clk);
        check_eq("t4_en_idle", en0, 0);
        run0 = 1'b1;
        wait_en0(5);
        pulse0(8'd20); pulse0(8'd20); pulse0(8'd20);
        check_eq("t4_lvl_3caps", lvl0, 0);
        pulse0(8'd20);
        check_eq("t4_lvl_word", lvl0, 1);
        check_eq("t4_data", if0.m_data, 20);
        @(negedge clk);
        check_eq("t4_lvl_drain", lvl0, 0);

        // 5: pass-through, forced push while full, overrun clear on run rise
        run1 = 1'b1;
        wait_en1(5);
        pulse1(8'd7);
        check_eq("t5_lvl1", lvl1, 1);
        check_eq("t5_d7", if1.m_data, 7);
        pulse1(8'd200);
        check_eq("t5_lvl2", lvl1, 2);
        check_eq("t5_en_hold", en1, 0);
        force u_dut1.push_req = 1'b1;
        @(negedge clk);
        release u_dut1.push_req;
        check_eq("t5_ovr_set", ovr1, 1);
        check_eq("t5_lvl_kept", lvl1, 2);
        check_eq("t5_head_kept", if1.m_data, 7);
        run1 = 1'b0;
        @(negedge clk);
        check_eq("t5_ovr_sticky", ovr1, 1);
        run1 = 1'b1;
        @(negedge clk);
        check_eq("t5_ovr_clr", ovr1, 0);
        if1.m_ready = 1'b1;
        check_eq("t5_pop7", if1.m_data, 7);
        @(negedge clk);
        check_eq("t5_pop200", if1.m_data, 200);
        @(negedge clk);
        check_eq("t5_lvl_empty", lvl1, 0);

        // 6: async reset mid-group with 3 words queued
        if0.m_ready = 1'b0;
        group0(8'd1, 8'd1, 8'd1, 8'd1);
        group0(8'd2, 8'd2, 8'd2, 8'd2);
        group0(8'd3, 8'd3, 8'd3, 8'd3);
        check_eq("t6_lvl3", lvl0, 3);
        pulse0(8'd5);
        pulse0(8'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", if0.m_valid, 0);
        check_eq("t6_lvl", lvl0, 0);
        check_eq("t6_en", en0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
